enemy_fire_scheduler: RTL and testbench

//  Picks which of the 24 enemies (3 rows x 8 cols, index = row*8+col) fires the enemy shot and when.
//  - Uses an LFSR to choose a column.
//  - Scans that column for its bottom-most live enemy.
//  - Waits for the enemy munition to be free, then pulses fire with the enemy ID.

---
 rtl/invaders_pkg.sv | 24 ++
 rtl/lfsr16.sv | 19 +
 rtl/enemy_fire_scheduler.sv | 123 ++++++++++++
 tb/tb_enemy_fire_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared constants and types for the enemy grid and its schedulers.
// Cell index is row*8+col over a 3x8 grid.
package invaders_pkg;

   localparam int N_COLS     = 8;
   localparam int N_ROWS     = 3;
   localparam int N_ENEMIES  = N_ROWS * N_COLS;
   localparam int ENEMY_ID_W = 6;

   typedef enum logic [1:0] {
      COOLDOWN,
      PICK,
      SCAN,
      ARM
   } state_t;

   function automatic logic [ENEMY_ID_W-1:0] cell_idx(
      input logic [1:0] row,
      input logic [2:0] col
   );
      return {1'b0, row, 3'b000} + {3'b000, col};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; steps every clock.
// Seed must be non-zero or the register locks at zero.
module lfsr16 (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic fb;

   assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

   always_ff @(posedge clk) begin
      if (reset) q <= seed;
      else       q <= {q[14:0], fb};
   end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Chooses which live enemy fires next: random column, bottom-most live
// enemy in it, then waits for the enemy munition before pulsing fire.
module enemy_fire_scheduler
   import invaders_pkg::*;
#(
   parameter int          COOLDOWN_CYC = 50_000_000,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [N_ENEMIES-1:0]  vivo_inimigo,
   input  logic                  municao_livre,
   output logic                  fire,
   output logic [ENEMY_ID_W-1:0] ID_enemy_tiro,
   output logic                  busy
);

   localparam int CNT_W = $clog2(COOLDOWN_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COOLDOWN_CYC);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [2:0]              col_q, col_d;
   logic [1:0]              row_q, row_d;
   logic [3:0]              tries_q, tries_d;
   logic [ENEMY_ID_W-1:0]   id_d;
   logic                    fire_d;
   logic [ENEMY_ID_W-1:0]   scan_idx;
   logic [15:0]             lfsr_q;
   logic                    lfsr_unused;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

   assign lfsr_unused = ^lfsr_q[15:3];
   assign scan_idx    = cell_idx(row_q, col_q);
   assign busy        = (state_q != COOLDOWN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      row_d   = row_q;
      tries_d = tries_q;
      id_d    = ID_enemy_tiro;
      fire_d  = 1'b0;
      if (!enable) begin
         state_d = COOLDOWN;
         cnt_d   = CNT_MAX;
      end else begin
         unique case (state_q)
            COOLDOWN: begin
               if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
               else             state_d = PICK;
            end
            PICK: begin
               if (vivo_inimigo == '0) begin
                  cnt_d   = CNT_MAX;
                  state_d = COOLDOWN;
               end else begin
                  col_d   = lfsr_q[2:0];
                  row_d   = 2'd2;
                  tries_d = '0;
                  state_d = SCAN;
               end
            end
            SCAN: begin
               if (vivo_inimigo[scan_idx[4:0]]) begin
                  id_d    = scan_idx;
                  state_d = ARM;
               end else if (row_q != 2'd0) begin
                  row_d = row_q - 1'b1;
               end else begin
                  col_d   = col_q + 1'b1;
                  row_d   = 2'd2;
                  tries_d = tries_q + 1'b1;
                  // every column visited: mask emptied under us
                  if (tries_q == 4'd7) begin
                     cnt_d   = CNT_MAX;
                     state_d = COOLDOWN;
                  end
               end
            end
            ARM: begin
               if (!vivo_inimigo[ID_enemy_tiro[4:0]]) begin
                  state_d = PICK;
               end else if (municao_livre) begin
                  fire_d  = 1'b1;
                  cnt_d   = CNT_MAX;
                  state_d = COOLDOWN;
               end
            end
            default: state_d = COOLDOWN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= COOLDOWN;
         cnt_q         <= CNT_MAX;
         col_q         <= '0;
         row_q         <= '0;
         tries_q       <= '0;
         ID_enemy_tiro <= '0;
         fire          <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         col_q         <= col_d;
         row_q         <= row_d;
         tries_q       <= tries_d;
         ID_enemy_tiro <= id_d;
         fire          <= fire_d;
      end
   end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler with a short cooldown.
// Column picks are predicted from an independent LFSR model.
module tb_enemy_fire_scheduler;

   localparam int          CD   = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [23:0] vivo = '0;
   logic        mun = 1'b0;
   logic        fire;
   logic [5:0]  id;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int fire_cnt = 0;
   int dbl_cnt = 0;
   logic fire_prev = 1'b0;
   logic [15:0] lfsr_m = SEED;

   enemy_fire_scheduler #(
      .COOLDOWN_CYC (CD),
      .LFSR_SEED    (SEED)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .vivo_inimigo  (vivo),
      .municao_livre (mun),
      .fire          (fire),
      .ID_enemy_tiro (id),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) lfsr_m <= SEED;
      else lfsr_m <= {lfsr_m[14:0],
                      lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      if (fire) fire_cnt++;
      if (fire && fire_prev) dbl_cnt++;
      fire_prev = fire;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (!busy && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic restart();
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; vivo = 24'hFFFFFF; mun = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      checks++; if (fire !== 1'b0) begin errors++;
         $display("FAIL reset_fire got=%b exp=0", fire); end
      checks++; if (id !== 6'd0) begin errors++;
         $display("FAIL reset_id got=%0d exp=0", id); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (dut.u_lfsr.q !== SEED) begin errors++;
         $display("FAIL reset_lfsr got=%h exp=%h", dut.u_lfsr.q, SEED); end
      reset = 1'b0;
   endtask

   task automatic test_first_fire();
      int n; int c; int c2; int f0;
      wait_busy(n);
      checks++; if (n !== CD + 1) begin errors++;
         $display("FAIL t1_pick_delay got=%0d exp=%0d", n, CD + 1); end
      c = int'(lfsr_m[2:0]);
      f0 = fire_cnt;
      step(2);
      checks++; if (fire !== 1'b0 || busy !== 1'b1) begin errors++;
         $display("FAIL t1_arm fire=%b busy=%b exp 0/1", fire, busy); end
      step(1);
      checks++; if (fire !== 1'b1) begin errors++;
         $display("FAIL t1_fire got=%b exp=1", fire); end
      checks++; if (id !== 6'(16 + c)) begin errors++;
         $display("FAIL t1_id got=%0d exp=%0d", id, 16 + c); end
      step(1);
      checks++; if (fire !== 1'b0 || fire_cnt - f0 !== 1) begin errors++;
         $display("FAIL t1_single fire=%b cnt=%0d exp 0/1", fire, fire_cnt - f0); end
      wait_busy(n);
      checks++; if (n !== CD) begin errors++;
         $display("FAIL t1_repick got=%0d exp=%0d", n, CD); end
      c2 = int'(lfsr_m[2:0]);
      step(3);
      checks++; if (fire !== 1'b1 || id !== 6'(16 + c2)) begin errors++;
         $display("FAIL t1_fire2 fire=%b id=%0d exp 1/%0d", fire, id, 16 + c2); end
   endtask

   task automatic test_wrap();
      int n; int c; int k; int f0;
      vivo = 24'h000008; mun = 1'b1;
      restart();
      wait_busy(n);
      checks++; if (n !== CD + 1) begin errors++;
         $display("FAIL t2_pick_delay got=%0d exp=%0d", n, CD + 1); end
      c = int'(lfsr_m[2:0]);
      k = (3 - c + 8) % 8;
      f0 = fire_cnt;
      n = 0;
      while (!fire && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n !== 3 * k + 5) begin errors++;
         $display("FAIL t2_latency got=%0d exp=%0d col=%0d", n, 3 * k + 5, c); end
      checks++; if (id !== 6'd3) begin errors++;
         $display("FAIL t2_id got=%0d exp=3", id); end
      step(1);
      checks++; if (fire_cnt - f0 !== 1) begin errors++;
         $display("FAIL t2_once got=%0d exp=1", fire_cnt - f0); end
   endtask

   task automatic test_empty();
      int n; int f0;
      vivo = 24'h000000; mun = 1'b1;
      f0 = fire_cnt;
      restart();
      wait_busy(n);
      checks++; if (n !== CD + 1) begin errors++;
         $display("FAIL t3_pick_delay got=%0d exp=%0d", n, CD + 1); end
      step(1);
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL t3_busy_pulse got=%b exp=0", busy); end
      wait_busy(n);
      checks++; if (n !== CD + 1) begin errors++;
         $display("FAIL t3_period got=%0d exp=%0d", n, CD + 1); end
      step(2);
      checks++; if (fire_cnt - f0 !== 0) begin errors++;
         $display("FAIL t3_nofire got=%0d exp=0", fire_cnt - f0); end
   endtask

   task automatic test_target_killed();
      int n; int c; int k; int f0;
      vivo = 24'h000404; mun = 1'b0;
      restart();
      wait_busy(n);
      c = int'(lfsr_m[2:0]);
      k = (2 - c + 8) % 8;
      step(3 * k + 3);
      checks++; if (busy !== 1'b1 || id !== 6'd10) begin errors++;
         $display("FAIL t4_arm busy=%b id=%0d exp 1/10", busy, id); end
      f0 = fire_cnt;
      step(20);
      checks++; if (fire_cnt - f0 !== 0 || busy !== 1'b1 || id !== 6'd10) begin
         errors++;
         $display("FAIL t4_hold fires=%0d busy=%b id=%0d exp 0/1/10",
                  fire_cnt - f0, busy, id);
      end
      vivo = 24'h000004;
      step(1);
      c = int'(lfsr_m[2:0]);
      k = (2 - c + 8) % 8;
      step(3 * k + 4);
      checks++; if (busy !== 1'b1 || id !== 6'd2 || fire_cnt - f0 !== 0) begin
         errors++;
         $display("FAIL t4_repick busy=%b id=%0d fires=%0d exp 1/2/0",
                  busy, id, fire_cnt - f0);
      end
      mun = 1'b1;
      step(1);
      checks++; if (fire !== 1'b1 || id !== 6'd2) begin errors++;
         $display("FAIL t4_fire fire=%b id=%0d exp 1/2", fire, id); end
   endtask

   task automatic test_enable_drop();
      int n; int c; int k; int f0;
      vivo = 24'h000008; mun = 1'b1;
      restart();
      wait_busy(n);
      f0 = fire_cnt;
      step(2);
      enable = 1'b0;
      step(1);
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL t5_scan_abort busy=%b exp=0", busy); end
      step(2);
      enable = 1'b1;
      wait_busy(n);
      checks++; if (n !== CD + 1) begin errors++;
         $display("FAIL t5_reload got=%0d exp=%0d", n, CD + 1); end
      mun = 1'b0;
      c = int'(lfsr_m[2:0]);
      k = (3 - c + 8) % 8;
      step(3 * k + 4);
      checks++; if (busy !== 1'b1 || id !== 6'd3) begin errors++;
         $display("FAIL t5_arm busy=%b id=%0d exp 1/3", busy, id); end
      enable = 1'b0; mun = 1'b1;
      step(1);
      checks++; if (fire !== 1'b0 || busy !== 1'b0 || id !== 6'd3) begin errors++;
         $display("FAIL t5_arm_abort fire=%b busy=%b id=%0d exp 0/0/3",
                  fire, busy, id);
      end
      enable = 1'b1;
      wait_busy(n);
      checks++; if (n !== CD + 1 || fire_cnt - f0 !== 0) begin errors++;
         $display("FAIL t5_cooldown n=%0d fires=%0d exp %0d/0",
                  n, fire_cnt - f0, CD + 1);
      end
   endtask

   task automatic test_reset_in_arm();
      int n; int c;
      vivo = 24'hFFFFFF; mun = 1'b0;
      restart();
      wait_busy(n);
      c = int'(lfsr_m[2:0]);
      step(2);
      checks++; if (busy !== 1'b1 || id !== 6'(16 + c)) begin errors++;
         $display("FAIL t6_arm busy=%b id=%0d exp 1/%0d", busy, id, 16 + c); end
      reset = 1'b1; mun = 1'b1;
      step(1);
      checks++; if (fire !== 1'b0 || id !== 6'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL t6_reset fire=%b id=%0d busy=%b exp 0/0/0",
                  fire, id, busy);
      end
      checks++; if (dut.u_lfsr.q !== SEED) begin errors++;
         $display("FAIL t6_lfsr got=%h exp=%h", dut.u_lfsr.q, SEED); end
      reset = 1'b0;
      step(1);
      checks++; if (fire !== 1'b0) begin errors++;
         $display("FAIL t6_after fire=%b exp=0", fire); end
      step(1);
      checks++; if (dbl_cnt !== 0) begin errors++;
         $display("FAIL double_fire got=%0d exp=0", dbl_cnt); end
   endtask

   initial begin
      test_reset();
      test_first_fire();
      test_wrap();
      test_empty();
      test_target_killed();
      test_enable_drop();
      test_reset_in_arm();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
